// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, decode control and
// the IF/ID register consumers. master = fetch unit side.
interface if_fetch_unit_if;
  logic [31:0] im_pc;
  logic        im_busy;
  logic [31:0] im_instr;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_adel;
  logic [31:0] fetch_cnt;
  logic [31:0] busy_cnt;

  modport master (
    output im_pc,
    input  im_busy,
    input  im_instr,
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output ifid_valid,
    output ifid_pc,
    output ifid_instr,
    output ifid_adel,
    output fetch_cnt,
    output busy_cnt
  );

  modport slave (
    input  im_pc,
    output im_busy,
    output im_instr,
    output stall,
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_pc,
    input  ifid_instr,
    input  ifid_adel,
    input  fetch_cnt,
    input  busy_cnt
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, qualifies memory data with im_busy,
// applies redirect/flush/stall and drives the IF/ID register plus fetch counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic             clk,
  input logic             reset,
  if_fetch_unit_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        adel_q, adel_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic        misaligned;

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    adel_d       = adel_q;
    fetch_cnt_d  = fetch_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    misaligned   = (pc_q[1:0] != 2'b00);

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
    end else if (bus.flush) begin
      // PC held so the word already at the memory is delivered later
      valid_d = 1'b0;
    end else if (bus.stall) begin
      if (bus.im_busy) begin
        busy_cnt_d = busy_cnt_q + 32'd1;
      end
    end else if (!bus.im_busy) begin
      valid_d      = 1'b1;
      ifid_pc_d    = pc_q;
      adel_d       = misaligned;
      ifid_instr_d = misaligned ? '0 : bus.im_instr;
      pc_d         = pc_q + 32'd4;
      fetch_cnt_d  = fetch_cnt_q + 32'd1;
    end else begin
      valid_d    = 1'b0;
      busy_cnt_d = busy_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      adel_q       <= 1'b0;
      fetch_cnt_q  <= '0;
      busy_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      adel_q       <= adel_d;
      fetch_cnt_q  <= fetch_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign bus.im_pc      = pc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_adel  = adel_q;
  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: one-cycle-busy memory model, directed scenarios and
// randomized control traffic checked against a cycle-level rule model.
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Instruction memory: registers the address each edge, busy while it differs
  logic [31:0] mem_addr_q;
  always_ff @(posedge clk) begin
    if (!reset) mem_addr_q <= '0;
    else        mem_addr_q <= bus.im_pc;
  end
  assign bus.im_busy  = (bus.im_pc != mem_addr_q);
  assign bus.im_instr = bus.im_busy ? 32'hDEAD_BEEF : word_of(bus.im_pc);

  // Reference model state
  logic [31:0] m_pc, m_mem, m_ipc, m_instr, m_fc, m_bc;
  logic        m_valid, m_adel;

  task automatic model_edge();
    logic busy;
    if (!reset) begin
      m_pc = RST_PC; m_mem = '0; m_valid = 1'b0; m_ipc = '0;
      m_instr = '0; m_adel = 1'b0; m_fc = '0; m_bc = '0;
    end else begin
      busy  = (m_pc != m_mem);
      m_mem = m_pc;
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc; m_valid = 1'b0;
      end else if (bus.flush) begin
        m_valid = 1'b0;
      end else if (bus.stall) begin
        if (busy) m_bc = m_bc + 1;
      end else if (!busy) begin
        m_valid = 1'b1;
        m_ipc   = m_pc;
        m_adel  = (m_pc % 4) != 0;
        m_instr = m_adel ? 32'd0 : word_of(m_pc);
        m_pc    = m_pc + 4;
        m_fc    = m_fc + 1;
      end else begin
        m_valid = 1'b0;
        m_bc    = m_bc + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step(); step();
    n_checks++; if (bus.im_pc !== RST_PC) begin n_fail++; $display("FAIL reset_im_pc got=%h exp=%h", bus.im_pc, RST_PC); end
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.ifid_valid); end
    n_checks++; if (bus.ifid_pc !== 32'd0) begin n_fail++; $display("FAIL reset_ifid_pc got=%h exp=0", bus.ifid_pc); end
    n_checks++; if (bus.ifid_instr !== 32'd0) begin n_fail++; $display("FAIL reset_ifid_instr got=%h exp=0", bus.ifid_instr); end
    n_checks++; if (bus.ifid_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel got=%b exp=0", bus.ifid_adel); end
    n_checks++; if (bus.fetch_cnt !== 32'd0 || bus.busy_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.fetch_cnt, bus.busy_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    logic [6:0] pat;
    pat = 7'b1010100; // cycle 0 at bit 0: 0,0,1,0,1,0,1
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c <= 6) begin
        n_checks++;
        if (bus.ifid_valid !== pat[c]) begin n_fail++; $display("FAIL freerun_valid c=%0d got=%b exp=%b", c, bus.ifid_valid, pat[c]); end
      end
      if (c == 2 || c == 4 || c == 6) begin
        n_checks++;
        if (bus.ifid_pc !== RST_PC + 32'((c - 2) * 2)) begin
          n_fail++; $display("FAIL freerun_pc c=%0d got=%h exp=%h", c, bus.ifid_pc, RST_PC + 32'((c - 2) * 2));
        end
      end
      if (c == 9) begin
        n_checks++;
        if (bus.fetch_cnt !== 32'd4 || bus.busy_cnt !== 32'd5) begin
          n_fail++; $display("FAIL freerun_counters got=%0d/%0d exp=4/5", bus.fetch_cnt, bus.busy_cnt);
        end
      end
      if (c < 9) step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) step();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h3004 || bus.im_pc !== 32'h3008) begin
        n_fail++; $display("FAIL stall_hold k=%0d got v=%b pc=%h im=%h exp v=1 pc=3004 im=3008",
                           k, bus.ifid_valid, bus.ifid_pc, bus.im_pc);
      end
    end
    bus.stall = 1'b0;
    step();
    n_checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h3008 || bus.ifid_instr !== word_of(32'h3008)) begin
      n_fail++; $display("FAIL stall_release got v=%b pc=%h instr=%h exp v=1 pc=3008 instr=%h",
                         bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, word_of(32'h3008));
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    repeat (4) step();
    bus.stall = 1'b1; bus.flush = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4000;
    step();
    idle();
    n_checks++;
    if (bus.ifid_valid !== 1'b0 || bus.im_pc !== 32'h4000) begin
      n_fail++; $display("FAIL redir_next got v=%b im=%h exp v=0 im=4000", bus.ifid_valid, bus.im_pc);
    end
    step();
    n_checks++;
    if (bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got v=%b exp=0", bus.ifid_valid); end
    step();
    n_checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h4000 || bus.fetch_cnt !== 32'd3) begin
      n_fail++; $display("FAIL redir_target got v=%b pc=%h fc=%0d exp v=1 pc=4000 fc=3",
                         bus.ifid_valid, bus.ifid_pc, bus.fetch_cnt);
    end
  endtask

  task automatic test_misaligned();
    int unsigned n;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4002;
    step();
    idle();
    n = 0;
    while (bus.ifid_valid !== 1'b1 && n < 8) begin step(); n++; end
    n_checks++;
    if (n >= 8) begin n_fail++; $display("FAIL misaligned_timeout got=no_valid exp=valid within 8"); end
    else if (bus.ifid_pc !== 32'h4002 || bus.ifid_adel !== 1'b1 || bus.ifid_instr !== 32'd0 || bus.im_pc !== 32'h4006) begin
      n_fail++; $display("FAIL misaligned got pc=%h adel=%b instr=%h im=%h exp pc=4002 adel=1 instr=0 im=4006",
                         bus.ifid_pc, bus.ifid_adel, bus.ifid_instr, bus.im_pc);
    end
  endtask

  task automatic test_wrap();
    int unsigned n;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    idle();
    n = 0;
    while (bus.ifid_valid !== 1'b1 && n < 8) begin step(); n++; end
    n_checks++;
    if (n >= 8) begin n_fail++; $display("FAIL wrap_timeout got=no_valid exp=valid within 8"); end
    else if (bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_adel !== 1'b0 ||
             bus.ifid_instr !== word_of(32'hFFFF_FFFC) || bus.im_pc !== 32'd0) begin
      n_fail++; $display("FAIL wrap got pc=%h adel=%b instr=%h im=%h exp pc=fffffffc adel=0 instr=%h im=0",
                         bus.ifid_pc, bus.ifid_adel, bus.ifid_instr, bus.im_pc, word_of(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_redirect_same();
    int unsigned n;
    logic [31:0] tgt, fc0;
    n = 0;
    while (bus.im_busy !== 1'b0 && n < 4) begin step(); n++; end
    tgt = m_pc;
    fc0 = m_fc;
    bus.redirect_valid = 1'b1; bus.redirect_pc = tgt;
    step();
    idle();
    n_checks++;
    if (bus.im_pc !== tgt || bus.im_busy !== 1'b0 || bus.ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL same_redir got im=%h busy=%b v=%b exp im=%h busy=0 v=0",
                         bus.im_pc, bus.im_busy, bus.ifid_valid, tgt);
    end
    step();
    n_checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== tgt || bus.fetch_cnt !== fc0 + 32'd1) begin
      n_fail++; $display("FAIL same_deliver got v=%b pc=%h fc=%0d exp v=1 pc=%h fc=%0d",
                         bus.ifid_valid, bus.ifid_pc, bus.fetch_cnt, tgt, fc0 + 32'd1);
    end
  endtask

  task automatic test_reset_pulse();
    int unsigned n;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_checks++;
    if (bus.im_pc !== RST_PC || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'd0 || bus.ifid_instr !== 32'd0 ||
        bus.ifid_adel !== 1'b0 || bus.fetch_cnt !== 32'd0 || bus.busy_cnt !== 32'd0) begin
      n_fail++; $display("FAIL pulse_reset got im=%h v=%b pc=%h in=%h ad=%b fc=%0d bc=%0d exp im=%h all others 0",
                         bus.im_pc, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_adel,
                         bus.fetch_cnt, bus.busy_cnt, RST_PC);
    end
    n = 0;
    while (bus.ifid_valid !== 1'b1 && n < 6) begin step(); n++; end
    n_checks++;
    if (n >= 6 || bus.ifid_pc !== RST_PC || bus.fetch_cnt !== 32'd1 || bus.busy_cnt !== 32'd1) begin
      n_fail++; $display("FAIL pulse_restart got v=%b pc=%h fc=%0d bc=%0d exp v=1 pc=%h fc=1 bc=1",
                         bus.ifid_valid, bus.ifid_pc, bus.fetch_cnt, bus.busy_cnt, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [161:0] got, exp;
    int unsigned sel;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       bus.redirect_pc = m_pc;
        1:       bus.redirect_pc = 32'h0001_0000 + ($urandom_range(0, 255) * 4);
        2:       bus.redirect_pc = 32'h0002_0000 + $urandom_range(0, 1023);
        default: bus.redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
      endcase
      reset = ($urandom_range(0, 99) != 0);
      step();
      got = {bus.im_pc, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_adel, bus.fetch_cnt, bus.busy_cnt};
      exp = {m_pc, m_valid, m_ipc, m_instr, m_adel, m_fc, m_bc};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_priority();
    test_misaligned();
    test_wrap();
    test_redirect_same();
    test_reset_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, presents it to instruction memory, and uses the memory's one-cycle `im_busy` indication to decide when the fetched word is valid. It applies branch/jump redirects and downstream stall/flush, and drives the IF/ID pipeline register consumed by decode. It also keeps fetch performance counters.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded during reset.

Ports:
- `clk`, input, 1, clock; all state updates on its rising edge.
- `reset`, input, 1, synchronous, active-low reset.
- `im_pc`, output, 32, fetch address presented to instruction memory.
- `im_busy`, input, 1, memory busy flag.
  - High when `im_pc` differs from the address the memory registered on the previous edge.
  - Low when `im_instr` is valid for `im_pc`.
- `im_instr`, input, 32, instruction word for `im_pc`; only sampled when `im_busy`=0.
- `stall`, input, 1, decode cannot accept a new instruction.
- `flush`, input, 1, kill the IF/ID contents.
- `redirect_valid`, input, 1, branch/jump/exception redirect request.
- `redirect_pc`, input, 32, redirect target.
- `ifid_valid`, output, 1, IF/ID holds a real instruction.
- `ifid_pc`, output, 32, PC of the IF/ID instruction.
- `ifid_instr`, output, 32, IF/ID instruction word. Forced to 0 (nop) when `ifid_adel`=1.
- `ifid_adel`, output, 1, IF/ID PC is not word-aligned (address error on fetch).
- `fetch_cnt`, output, 32, number of instructions written into IF/ID.
- `busy_cnt`, output, 32, number of cycles spent waiting on `im_busy`.

## Operation

Reset (`reset`=0, at an edge):
- `im_pc`=`RESET_PC`.
- `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=0, `ifid_adel`=0.
- `fetch_cnt`=0, `busy_cnt`=0.
- Reset takes effect mid-operation regardless of any other input.

Per-edge priority when `reset`=1 (highest first):
1. `redirect_valid`=1:
   - `im_pc` <= `redirect_pc`.
   - `ifid_valid` <= 0; this overrides `stall`.
   - Counters do not change.
   - The in-flight fetch is abandoned; the word is never delivered.
2. `flush`=1 (no redirect):
   - `ifid_valid` <= 0.
   - `im_pc` is held, even if `im_busy`=0; the held word is delivered on a later cycle.
3. `stall`=1:
   - All IF/ID outputs and `im_pc` are held.
   - `busy_cnt` still increments if `im_busy`=1.
4. `im_busy`=0 (deliver):
   - `ifid_valid` <= 1, `ifid_pc` <= `im_pc`.
   - `ifid_adel` <= (`im_pc[1:0]` != 0).
   - `ifid_instr` <= `ifid_adel` ? 0 : `im_instr`.
   - `im_pc` <= `im_pc` + 4.
   - `fetch_cnt` += 1.
5. `im_busy`=1 (wait):
   - `ifid_valid` <= 0 (bubble).
   - `im_pc` is held.
   - `busy_cnt` += 1.

Arithmetic and alignment:
- `im_pc` + 4 is 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000.
- Both counters wrap from 32'hFFFF_FFFF to 0.
- `ifid_pc`, `ifid_instr` and `ifid_adel` keep their last values when `ifid_valid` drops to 0. Only `ifid_valid` qualifies them.
- A misaligned PC is still presented unmodified on `im_pc`. The fetch proceeds, and the misaligned PC then advances by 4 like any other.

Other rules:
- Redirect target equal to the current `im_pc`: memory sees no address change, so `im_busy` stays 0. The word is delivered on the next edge unless stall, flush or another redirect intervenes.
- `im_busy` is the only validity indicator. The unit never samples `im_instr` when `im_busy`=1.

## Timing

- `im_pc` and all IF/ID outputs are registered; there is no combinational path from inputs to outputs.
- Memory behaviour is as defined above: after each `im_pc` change, `im_busy`=1 for exactly one cycle.
- Steady-state throughput is therefore one instruction per 2 cycles: one wait cycle (bubble) followed by one deliver cycle.
- After reset release (reset value of the memory's registered address is 0):
  - Cycle 0: `im_busy`=1.
  - Cycle 1: `im_busy`=0; the word is captured at the end of cycle 1.
  - `ifid_valid` first reads 1 in cycle 2.
- Redirect latency:
  - The target appears on `im_pc` in the cycle after `redirect_valid`.
  - The first valid IF/ID for the target appears 2 cycles after that, provided the target differs from the old PC.
- Stall release: when `stall` falls with `im_busy`=0, delivery happens on that same edge.

## Test plan

- Reset, then free-run with a memory model that asserts busy for one cycle per address change:
  - `ifid_pc` sequence is 0x3000, 0x3004, 0x3008.
  - `ifid_valid` pattern is 0,0,1,0,1,0,1.
  - After 10 cycles, `fetch_cnt`=4 and `busy_cnt`=5.
- Assert `stall` for 3 cycles while IF/ID holds 0x3004:
  - IF/ID and `im_pc`=0x3008 are frozen for all 3 cycles.
  - 0x3008 is delivered on the edge where `stall` falls.
- Assert redirect to 0x4000 in the same cycle as `stall`=1 and `flush`=1:
  - `ifid_valid`=0 and `im_pc`=0x4000 on the next cycle.
  - The 0x3008 word is never delivered.
  - The next valid IF/ID holds 0x4000 two cycles later.
- Redirect to 0x4002:
  - IF/ID shows `ifid_pc`=0x4002, `ifid_adel`=1, `ifid_instr`=0.
  - The next fetch is 0x4006.
- Redirect to 32'hFFFF_FFFC:
  - After delivery, `im_pc`=0.
- Redirect equal to the current `im_pc`:
  - No busy cycle; the word is delivered on the following edge.
- Pulse `reset`=0 for one cycle mid-stream:
  - All outputs return to their reset values and the fetch restarts at 0x3000.
